// File: rtl/m3_ramp_ctrl_if.sv
// Command/status bundle between the command layer (master) and m3_ramp_ctrl (slave).
interface m3_ramp_ctrl_if;
  logic        cmdStartI;
  logic        cmdStopI;
  logic        forceStopI;
  logic        speedINCi;
  logic        speedDECi;
  logic        nextCalc_1i;
  logic        m3startO;
  logic [31:0] dstRoundLenO;
  logic [2:0]  stateO;
  logic        atSpeedO;
  logic        faultO;

  modport master (
    output cmdStartI, cmdStopI, forceStopI, speedINCi, speedDECi, nextCalc_1i,
    input  m3startO, dstRoundLenO, stateO, atSpeedO, faultO
  );

  modport slave (
    input  cmdStartI, cmdStopI, forceStopI, speedINCi, speedDECi, nextCalc_1i,
    output m3startO, dstRoundLenO, stateO, atSpeedO, faultO
  );
endinterface

// File: rtl/m3_ramp_ctrl.sv
// Motor-3 ramp sequencer: start/stop/speed commands -> step-calculator enable and slice length.
// Optional stall watchdog enabled by defining M3_RAMP_STALL_WDG_EN.
module m3_ramp_ctrl #(
  parameter int unsigned             PERIOD_W    = 22,
  parameter logic [PERIOD_W-1:0]     PERIOD_MAX  = 22'd400000,
  parameter logic [PERIOD_W-1:0]     PERIOD_MIN  = 22'd2000,
  parameter logic [PERIOD_W-1:0]     PERIOD_INIT = 22'd100000,
  parameter logic [PERIOD_W-1:0]     RAMP_STEP   = 22'd20000,
  parameter logic [PERIOD_W-1:0]     SPEED_STEP  = 22'd1000,
  parameter logic [31:0]             WDG_LIMIT   = 32'd50000000
) (
  input  logic          clkI,
  input  logic          nRstI,
  m3_ramp_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRamp  = 3'd1,
    StRun   = 3'd2,
    StDecel = 3'd3,
    StHalt  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [PERIOD_W-1:0]   cur_q, cur_d;
  logic [PERIOD_W-1:0]   tgt_q, tgt_d;
  logic                  start_q, start_d;
  logic                  at_speed_q, at_speed_d;
  logic [PERIOD_W:0]     tgt_sub, tgt_add;
  logic                  wdg_trip;
  logic                  start_blocked;

  // Move cur toward goal by at most RAMP_STEP, landing exactly on goal when close.
  function automatic logic [PERIOD_W-1:0] ramp_toward(input logic [PERIOD_W-1:0] cur,
                                                      input logic [PERIOD_W-1:0] goal);
    logic [PERIOD_W-1:0] diff;
    if (goal >= cur) begin
      diff = goal - cur;
      return (diff > RAMP_STEP) ? cur + RAMP_STEP : goal;
    end else begin
      diff = cur - goal;
      return (diff > RAMP_STEP) ? cur - RAMP_STEP : goal;
    end
  endfunction

  always_comb begin
    tgt_d   = tgt_q;
    tgt_sub = {1'b0, tgt_q} - {1'b0, SPEED_STEP};
    tgt_add = {1'b0, tgt_q} + {1'b0, SPEED_STEP};
    if (bus.speedINCi && !bus.speedDECi) begin
      tgt_d = (tgt_sub[PERIOD_W] || (tgt_sub < {1'b0, PERIOD_MIN})) ? PERIOD_MIN
                                                                     : tgt_sub[PERIOD_W-1:0];
    end else if (bus.speedDECi && !bus.speedINCi) begin
      tgt_d = (tgt_add > {1'b0, PERIOD_MAX}) ? PERIOD_MAX : tgt_add[PERIOD_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    start_d = start_q;
    if (bus.forceStopI || wdg_trip) begin
      state_d = StIdle;
      start_d = 1'b0;
      cur_d   = PERIOD_MAX;
    end else if (bus.cmdStopI && (state_q == StRamp || state_q == StRun)) begin
      state_d = StDecel;
    end else if (bus.cmdStartI && !start_blocked &&
                 (state_q == StIdle || state_q == StDecel || state_q == StHalt)) begin
      state_d = StRamp;
      start_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: cur_d = PERIOD_MAX;
        StRamp: begin
          if (bus.nextCalc_1i) begin
            cur_d = ramp_toward(cur_q, tgt_q);
            if (cur_d == tgt_q) state_d = StRun;
          end
        end
        StRun: if (tgt_q != cur_q) state_d = StRamp;
        StDecel: begin
          if (bus.nextCalc_1i) begin
            cur_d = ramp_toward(cur_q, PERIOD_MAX);
            if (cur_d == PERIOD_MAX) state_d = StHalt;
          end
        end
        StHalt: begin
          // Drop the enable only on a round boundary.
          if (bus.nextCalc_1i) begin
            state_d = StIdle;
            start_d = 1'b0;
          end
        end
        default: begin
          state_d = StIdle;
          start_d = 1'b0;
          cur_d   = PERIOD_MAX;
        end
      endcase
    end
    at_speed_d = (state_d == StRun);
  end

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      state_q    <= StIdle;
      cur_q      <= PERIOD_MAX;
      tgt_q      <= PERIOD_INIT;
      start_q    <= 1'b0;
      at_speed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      tgt_q      <= tgt_d;
      start_q    <= start_d;
      at_speed_q <= at_speed_d;
    end
  end

`ifdef M3_RAMP_STALL_WDG_EN
  logic [31:0] wdg_q, wdg_d;
  logic        fault_q, fault_d;

  always_comb begin
    wdg_trip = start_q && !bus.nextCalc_1i && (wdg_q == WDG_LIMIT - 32'd1);
    wdg_d    = (!start_q || bus.nextCalc_1i || wdg_trip) ? 32'd0 : wdg_q + 32'd1;
    fault_d  = bus.forceStopI ? 1'b0 : (fault_q | wdg_trip);
  end

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      wdg_q   <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      wdg_q   <= wdg_d;
      fault_q <= fault_d;
    end
  end

  assign start_blocked = fault_q;
  assign bus.faultO    = fault_q;
`else
  logic unused_wdg_limit;
  assign unused_wdg_limit = ^WDG_LIMIT;
  assign wdg_trip         = 1'b0;
  assign start_blocked    = 1'b0;
  assign bus.faultO       = 1'b0;
`endif

  assign bus.m3startO     = start_q;
  assign bus.dstRoundLenO = 32'(cur_q);
  assign bus.stateO       = state_q;
  assign bus.atSpeedO     = at_speed_q;

endmodule
